// File: rtl/wave_if.sv
// Handshake bundle between wave_ctrl (master) and its environment: game FSM + enemies (slave).
// Output widths follow the respawn/move tables and level count the interface is built for.
interface wave_if #(
  parameter int N_ENEMY      = 8,
  parameter int N_LEVELS     = 8,
  parameter int BASE_RESPAWN = 9_999_999,
  parameter int BASE_MOVE    = 2_499_999
);
  localparam int RW = $clog2(BASE_RESPAWN + 1);
  localparam int MW = $clog2(BASE_MOVE + 1);
  localparam int LW = (N_LEVELS > 1) ? $clog2(N_LEVELS) : 1;

  logic               start;
  logic               gameover;
  logic               killed;
  logic [N_ENEMY-1:0] enemy_alive;
  logic               spawn_en;
  logic [RW-1:0]      respawn_ticks;
  logic [MW-1:0]      move_ticks;
  logic [LW-1:0]      level;
  logic               wave_start;
  logic               wave_clear;

  modport master (
    input  start, gameover, killed, enemy_alive,
    output spawn_en, respawn_ticks, move_ticks, level, wave_start, wave_clear
  );

  modport slave (
    output start, gameover, killed, enemy_alive,
    input  spawn_en, respawn_ticks, move_ticks, level, wave_start, wave_clear
  );
endinterface

// File: rtl/wave_ctrl.sv
// Wave scheduler: intro pause -> active spawning -> drain until board clear -> next level.
// Optional active-phase timeout enabled by defining WAVE_TIMEOUT_EN.
module wave_ctrl #(
  parameter int N_ENEMY        = 8,
  parameter int KILLS_PER_WAVE = 10,
  parameter int N_LEVELS       = 8,
  parameter int BASE_RESPAWN   = 9_999_999,
  parameter int RESPAWN_STEP   = 1_000_000,
  parameter int BASE_MOVE      = 2_499_999,
  parameter int MOVE_STEP      = 250_000,
  parameter int INTRO_TICKS    = 49_999_999
`ifdef WAVE_TIMEOUT_EN
  ,
  parameter int TIMEOUT_TICKS  = 499_999_999
`endif
) (
  input  logic   clk,
  input  logic   reset,
  wave_if.master bus
);
  localparam int RW  = $clog2(BASE_RESPAWN + 1);
  localparam int MW  = $clog2(BASE_MOVE + 1);
  localparam int LW  = (N_LEVELS > 1) ? $clog2(N_LEVELS) : 1;
  localparam int ICW = (INTRO_TICKS > 1) ? $clog2(INTRO_TICKS) : 1;
  localparam int KCW = $clog2(KILLS_PER_WAVE + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_INTRO  = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic [1:0]     state;
  logic [LW-1:0]  level_r;
  logic [KCW-1:0] kill_cnt;
  logic [ICW-1:0] intro_cnt;
  logic [RW-1:0]  respawn_r;
  logic [MW-1:0]  move_r;
  logic           wave_start_r;
  logic           wave_clear_r;
`ifdef WAVE_TIMEOUT_EN
  logic [31:0]    to_cnt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      level_r      <= '0;
      kill_cnt     <= '0;
      intro_cnt    <= '0;
      respawn_r    <= RW'(BASE_RESPAWN);
      move_r       <= MW'(BASE_MOVE);
      wave_start_r <= 1'b0;
      wave_clear_r <= 1'b0;
`ifdef WAVE_TIMEOUT_EN
      to_cnt       <= '0;
`endif
    end else begin
      wave_start_r <= 1'b0;
      wave_clear_r <= 1'b0;
      // Tables follow the registered level, so they lag a level change by one cycle.
      respawn_r    <= RW'(BASE_RESPAWN - int'(level_r) * RESPAWN_STEP);
      move_r       <= MW'(BASE_MOVE - int'(level_r) * MOVE_STEP);

      if (bus.gameover) begin
        state     <= S_IDLE;
        level_r   <= '0;
        kill_cnt  <= '0;
        intro_cnt <= '0;
`ifdef WAVE_TIMEOUT_EN
        to_cnt    <= '0;
`endif
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              state     <= S_INTRO;
              intro_cnt <= '0;
            end
          end
          S_INTRO: begin
            if (intro_cnt == ICW'(INTRO_TICKS - 1)) begin
              state        <= S_ACTIVE;
              intro_cnt    <= '0;
              wave_start_r <= 1'b1;
`ifdef WAVE_TIMEOUT_EN
              to_cnt       <= '0;
`endif
            end else begin
              intro_cnt <= intro_cnt + 1'b1;
            end
          end
          S_ACTIVE: begin
            if (bus.killed) begin
              if (kill_cnt == KCW'(KILLS_PER_WAVE - 1)) begin
                kill_cnt <= KCW'(KILLS_PER_WAVE);
                state    <= S_DRAIN;
              end else begin
                kill_cnt <= kill_cnt + 1'b1;
              end
            end
`ifdef WAVE_TIMEOUT_EN
            // Quota and timeout on the same edge both land in S_DRAIN.
            to_cnt <= to_cnt + 32'd1;
            if (to_cnt == 32'(TIMEOUT_TICKS - 1)) begin
              state <= S_DRAIN;
            end
`endif
          end
          S_DRAIN: begin
            if (bus.enemy_alive == {N_ENEMY{1'b0}}) begin
              state        <= S_INTRO;
              kill_cnt     <= '0;
              intro_cnt    <= '0;
              wave_clear_r <= 1'b1;
              if (level_r != LW'(N_LEVELS - 1)) begin
                level_r <= level_r + 1'b1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.spawn_en      = (state == S_ACTIVE);
  assign bus.respawn_ticks = respawn_r;
  assign bus.move_ticks    = move_r;
  assign bus.level         = level_r;
  assign bus.wave_start    = wave_start_r;
  assign bus.wave_clear    = wave_clear_r;

endmodule
